// File: rtl/ransac_iteration_scheduler.sv
// ransac_iteration_scheduler
//   Hands RANSAC iterations to a pool of plane checking units, collects their
//   results, retries bus failures and tracks the best inlier count of the run.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin a run (honoured only in IDLE or DONE)
//   total_iterations  iterations for the run, latched at start
//   busy / done       run in progress (RUN, DRAIN) / run finished (sticky)
//   fatal_error       run aborted after retry exhaustion
//   unit_start        one-cycle start pulse per unit
//   unit_iter_id      iteration id per unit, stable while that unit is busy
//   unit_done         per-unit level, held until unit_ack
//   unit_status       2-bit result per unit, valid with unit_done
//   unit_inliers      inlier count per unit, valid with unit_done and SUCCESS
//   unit_ack          one-cycle acknowledge of a unit_done
//   best_inliers, best_iter_id, best_valid   best SUCCESS of this run
//   error_count       non-SUCCESS results this run, saturating
//   dbg_state         current FSM state (IDLE=0 RUN=1 DRAIN=2 DONE=3)
//
// Handshakes: unit_start is a single-cycle command; the unit answers by
// raising unit_done (with status/inliers) and holding it until it observes a
// single-cycle unit_ack. A unit that raises unit_done while the scheduler
// considers it idle is ignored and never acknowledged.
//
// Status encoding: 0 SUCCESS, 1 DERIVE_PLANE_ERROR, 2 BUS_ERROR, 3 BUS_TIMEOUT.
module ransac_iteration_scheduler #(
  parameter int NUM_UNITS    = 4,
  parameter int ITER_WIDTH   = 16,
  parameter int INLIER_WIDTH = 32,
  parameter int MAX_RETRIES  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ITER_WIDTH-1:0]             total_iterations,
  output logic                              busy,
  output logic                              done,
  output logic                              fatal_error,
  output logic [NUM_UNITS-1:0]              unit_start,
  output logic [NUM_UNITS*ITER_WIDTH-1:0]   unit_iter_id,
  input  logic [NUM_UNITS-1:0]              unit_done,
  input  logic [NUM_UNITS*2-1:0]            unit_status,
  input  logic [NUM_UNITS*INLIER_WIDTH-1:0] unit_inliers,
  output logic [NUM_UNITS-1:0]              unit_ack,
  output logic [INLIER_WIDTH-1:0]           best_inliers,
  output logic [ITER_WIDTH-1:0]             best_iter_id,
  output logic                              best_valid,
  output logic [ITER_WIDTH-1:0]             error_count,
  output logic [1:0]                        dbg_state
);

  localparam logic [1:0] STAT_SUCCESS = 2'd0;
  localparam logic [1:0] STAT_DERIVE  = 2'd1;
  localparam int         RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_e;

  state_e                  state_q, state_d;
  logic [ITER_WIDTH-1:0]   total_q, next_iter_q, completed_q;
  logic [NUM_UNITS-1:0]    unit_busy_q, retry_pend_q;
  logic [RW-1:0]           retry_cnt_q [NUM_UNITS];
  logic [ITER_WIDTH-1:0]   iter_id_q   [NUM_UNITS];

  logic [NUM_UNITS-1:0]    disp_oh, ack_oh, release_oh, busy_d;
  logic                    disp_any, ack_any, disp_en, ack_en;
  logic [1:0]              ack_status;
  logic [INLIER_WIDTH-1:0] ack_inl;
  logic [ITER_WIDTH-1:0]   ack_iter;
  logic [RW-1:0]           ack_rcnt;
  logic                    retry_ok, fatal_now, start_go;

  // Lowest-index idle unit for dispatch and lowest-index busy unit with a
  // result for acknowledge. The loop runs downward so the lowest index wins.
  // A unit waiting for its re-pulse is excluded from acking so a result that
  // has not yet been withdrawn cannot be consumed twice.
  always_comb begin
    disp_any   = 1'b0;
    disp_oh    = '0;
    ack_any    = 1'b0;
    ack_oh     = '0;
    ack_status = '0;
    ack_inl    = '0;
    ack_iter   = '0;
    ack_rcnt   = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (!unit_busy_q[i]) begin
        disp_any = 1'b1;
        disp_oh  = '0;
        disp_oh[i] = 1'b1;
      end
      if (unit_busy_q[i] && unit_done[i] && !retry_pend_q[i]) begin
        ack_any    = 1'b1;
        ack_oh     = '0;
        ack_oh[i]  = 1'b1;
        ack_status = unit_status[i*2 +: 2];
        ack_inl    = unit_inliers[i*INLIER_WIDTH +: INLIER_WIDTH];
        ack_iter   = iter_id_q[i];
        ack_rcnt   = retry_cnt_q[i];
      end
    end
  end

  assign start_go  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign disp_en   = disp_any && (state_q == S_RUN) && (next_iter_q < total_q);
  assign ack_en    = ack_any && (state_q == S_RUN || state_q == S_DRAIN);
  // Bus failures retry only while running; in DRAIN the unit is simply released.
  assign retry_ok  = ack_en && ack_status[1] && (state_q == S_RUN) && (int'(ack_rcnt) < MAX_RETRIES);
  assign fatal_now = ack_en && ack_status[1] && (state_q == S_RUN) && !retry_ok;
  assign release_oh = (ack_en && !retry_ok) ? ack_oh : '0;
  assign busy_d     = (unit_busy_q | (disp_en ? disp_oh : '0)) & ~release_oh;

  assign unit_start = (disp_en ? disp_oh : '0) | retry_pend_q;
  assign unit_ack   = ack_en ? ack_oh : '0;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign dbg_state  = state_q;

  // A freshly dispatched unit shows next_iter during its start pulse; the
  // registered copy takes over from the following cycle.
  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_id
    assign unit_iter_id[g*ITER_WIDTH +: ITER_WIDTH] =
      (disp_en && disp_oh[g]) ? next_iter_q : iter_id_q[g];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (total_iterations == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (fatal_now) state_d = S_DRAIN;
        else if (completed_q == total_q && unit_busy_q == '0) state_d = S_DONE;
      end
      S_DRAIN: if (unit_busy_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      total_q      <= '0;
      next_iter_q  <= '0;
      completed_q  <= '0;
      unit_busy_q  <= '0;
      retry_pend_q <= '0;
      best_inliers <= '0;
      best_iter_id <= '0;
      best_valid   <= 1'b0;
      error_count  <= '0;
      fatal_error  <= 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        retry_cnt_q[i] <= '0;
        iter_id_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      retry_pend_q <= '0;
      if (start_go) begin
        total_q      <= total_iterations;
        next_iter_q  <= '0;
        completed_q  <= '0;
        best_inliers <= '0;
        best_iter_id <= '0;
        best_valid   <= 1'b0;
        error_count  <= '0;
        fatal_error  <= 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) retry_cnt_q[i] <= '0;
      end else begin
        unit_busy_q <= busy_d;
        if (disp_en) begin
          next_iter_q <= next_iter_q + 1'b1;
          for (int i = 0; i < NUM_UNITS; i++) begin
            if (disp_oh[i]) begin
              iter_id_q[i]   <= next_iter_q;
              retry_cnt_q[i] <= '0;
            end
          end
        end
        if (ack_en) begin
          if (ack_status != STAT_SUCCESS && error_count != '1)
            error_count <= error_count + 1'b1;
          if (ack_status == STAT_SUCCESS || ack_status == STAT_DERIVE)
            completed_q <= completed_q + 1'b1;
          if (ack_status == STAT_SUCCESS && (!best_valid || ack_inl > best_inliers)) begin
            best_inliers <= ack_inl;
            best_iter_id <= ack_iter;
            best_valid   <= 1'b1;
          end
          if (retry_ok) begin
            retry_pend_q <= ack_oh;
            for (int i = 0; i < NUM_UNITS; i++)
              if (ack_oh[i]) retry_cnt_q[i] <= retry_cnt_q[i] + 1'b1;
          end
          if (fatal_now) fatal_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ransac_iteration_scheduler.sv
// Testbench for ransac_iteration_scheduler: behavioural unit models answer
// start pulses after a per-unit latency with a per-iteration/attempt result
// plan; every expected start (cycle offset, unit, id) is queued up front and
// compared when the scheduler pulses unit_start.
module tb_ransac_iteration_scheduler;

  localparam int NU = 4;
  localparam int IW = 16;
  localparam int LW = 32;
  localparam logic [1:0] SUCC = 2'd0, DERV = 2'd1, BERR = 2'd2, BTMO = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [IW-1:0]    total_iterations = '0;
  logic             busy, done, fatal_error;
  logic [NU-1:0]    unit_start, unit_ack;
  logic [NU*IW-1:0] unit_iter_id;
  logic [NU-1:0]    unit_done = '0;
  logic [NU*2-1:0]  unit_status = '0;
  logic [NU*LW-1:0] unit_inliers = '0;
  logic [LW-1:0]    best_inliers;
  logic [IW-1:0]    best_iter_id, error_count;
  logic             best_valid;
  logic [1:0]       dbg_state;

  ransac_iteration_scheduler #(.NUM_UNITS(NU), .ITER_WIDTH(IW), .INLIER_WIDTH(LW), .MAX_RETRIES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .total_iterations(total_iterations),
    .busy(busy), .done(done), .fatal_error(fatal_error),
    .unit_start(unit_start), .unit_iter_id(unit_iter_id),
    .unit_done(unit_done), .unit_status(unit_status), .unit_inliers(unit_inliers),
    .unit_ack(unit_ack), .best_inliers(best_inliers), .best_iter_id(best_iter_id),
    .best_valid(best_valid), .error_count(error_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [27:0] exp_q[$];          // {cycle offset[7:0], unit[3:0], iter id[15:0]}
  int n_checks = 0;
  int n_pass   = 0;
  int t0       = 0;
  int ack_cnt [NU];
  int ack_cyc [NU];
  bit busy_seen = 0;

  // ---------------- unit model plan ----------------
  logic [1:0]    plan_st  [16][4];
  logic [LW-1:0] plan_inl [16];
  int            attempts [16];
  int            lat      [NU];
  int            rem      [NU];
  bit            active   [NU];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic exp_start(input int off, input int u, input int id);
    exp_q.push_back({8'(off), 4'(u), 16'(id)});
  endtask

  task automatic plan_reset();
    for (int i = 0; i < 16; i++) begin
      for (int a = 0; a < 4; a++) plan_st[i][a] = SUCC;
      plan_inl[i] = '0;
      attempts[i] = 0;
    end
    for (int u = 0; u < NU; u++) begin
      lat[u] = 3; ack_cnt[u] = 0; ack_cyc[u] = -1;
    end
  endtask

  task automatic models_clear_unit(input int u);
    unit_done[u] = 1'b0;
    active[u]    = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    for (int u = 0; u < NU; u++) models_clear_unit(u);
    plan_reset();
    busy_seen = 0;
  endtask

  task automatic run_start(input logic [IW-1:0] n);
    @(posedge clk); #1 total_iterations = n; start = 1'b1; t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    check("done_reached", done, 1);
  endtask

  task automatic check_queue_empty(input string tag);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- unit models (drive after each active edge) ----------------
  initial begin
    logic [NU-1:0]    st_s, ack_s;
    logic [NU*IW-1:0] ids_s;
    int id, att;
    for (int u = 0; u < NU; u++) begin active[u] = 0; rem[u] = 0; end
    forever begin
      @(negedge clk);
      st_s = unit_start; ack_s = unit_ack; ids_s = unit_iter_id;
      @(posedge clk); #1;
      for (int u = 0; u < NU; u++) begin
        if (ack_s[u]) unit_done[u] = 1'b0;
        if (st_s[u]) begin
          id  = int'(ids_s[u*IW +: IW]) & 15;
          att = (attempts[id] > 3) ? 3 : attempts[id];
          attempts[id]++;
          unit_status[u*2 +: 2]   = plan_st[id][att];
          unit_inliers[u*LW +: LW] = plan_inl[id];
          unit_done[u] = 1'b0;
          rem[u]    = lat[u] - 1;
          active[u] = 1'b1;
        end else if (active[u]) begin
          rem[u] = rem[u] - 1;
        end
        if (active[u] && rem[u] <= 0) begin
          unit_done[u] = 1'b1;
          active[u]    = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor: pop expected starts, log acks ----------------
  always @(negedge clk) begin
    logic [27:0] got, e;
    if (busy === 1'b1) busy_seen = 1;
    for (int u = 0; u < NU; u++) begin
      if (unit_ack[u] === 1'b1) begin ack_cnt[u]++; ack_cyc[u] = cyc; end
      if (unit_start[u] === 1'b1) begin
        got = {8'(cyc - t0), 4'(u), unit_iter_id[u*IW +: IW]};
        check("start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("unit_start", got, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    plan_reset();
    do_reset();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fatal", fatal_error, 0);
    check("rst_best_valid", best_valid, 0);
    check("rst_best_inliers", best_inliers, 0);
    check("rst_error_count", error_count, 0);
    check("rst_unit_start", unit_start, 0);
    check("rst_state", dbg_state, 0);

    // 1: six successful iterations over four units
    plan_inl[0] = 10; plan_inl[1] = 40; plan_inl[2] = 25;
    plan_inl[3] = 40; plan_inl[4] = 5;  plan_inl[5] = 30;
    exp_start(1, 0, 0); exp_start(2, 1, 1); exp_start(3, 2, 2);
    exp_start(4, 3, 3); exp_start(5, 0, 4); exp_start(6, 1, 5);
    run_start(6);
    wait_done(60);
    check("t1_busy", busy, 0);
    check("t1_best_inliers", best_inliers, 40);
    check("t1_best_iter_id", best_iter_id, 1);
    check("t1_best_valid", best_valid, 1);
    check("t1_error_count", error_count, 0);
    check("t1_fatal", fatal_error, 0);
    check_queue_empty("t1_starts_consumed");

    // 2: zero iterations finishes immediately
    do_reset();
    run_start(0);
    @(negedge clk);
    check("t2_done_t1", done, 1);
    check("t2_best_valid", best_valid, 0);
    repeat (4) @(negedge clk);
    check("t2_busy_never", busy_seen, 0);
    check_queue_empty("t2_no_starts");

    // 3: two bus timeouts then success on unit 0
    do_reset();
    plan_st[0][0] = BTMO; plan_st[0][1] = BTMO; plan_st[0][2] = SUCC; plan_inl[0] = 7;
    exp_start(1, 0, 0); exp_start(5, 0, 0); exp_start(9, 0, 0);
    run_start(1);
    wait_done(60);
    check("t3_error_count", error_count, 2);
    check("t3_best_inliers", best_inliers, 7);
    check("t3_best_iter_id", best_iter_id, 0);
    check("t3_fatal", fatal_error, 0);
    check_queue_empty("t3_starts_consumed");

    // 4: retry exhaustion on unit 1 while unit 0 still works
    do_reset();
    lat[0] = 20; lat[1] = 2;
    plan_inl[0] = 9;
    for (int a = 0; a < 4; a++) plan_st[1][a] = BERR;
    exp_start(1, 0, 0); exp_start(2, 1, 1); exp_start(5, 1, 1); exp_start(8, 1, 1);
    run_start(2);
    begin
      int k;
      k = 0;
      while (fatal_error !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    end
    check("t4_fatal_set", fatal_error, 1);
    check("t4_state_drain", dbg_state, 2);
    check("t4_fatal_cycle", cyc - t0, 11);
    wait_done(60);
    check("t4_fatal_final", fatal_error, 1);
    check("t4_best_inliers", best_inliers, 9);
    check("t4_best_iter_id", best_iter_id, 0);
    check("t4_error_count", error_count, 3);
    check("t4_unit0_acked", ack_cnt[0], 1);
    check_queue_empty("t4_no_late_starts");

    // 5: simultaneous completions on units 0 and 2, one derive error
    do_reset();
    lat[0] = 4; lat[1] = 10; lat[2] = 2;
    plan_inl[0] = 100; plan_inl[1] = 50; plan_st[2][0] = DERV;
    exp_start(1, 0, 0); exp_start(2, 1, 1); exp_start(3, 2, 2);
    run_start(3);
    wait_done(60);
    check("t5_ack0_cycle", ack_cyc[0] - t0, 5);
    check("t5_ack2_after_ack0", ack_cyc[2] - ack_cyc[0], 1);
    check("t5_error_count", error_count, 1);
    check("t5_best_inliers", best_inliers, 100);
    check("t5_fatal", fatal_error, 0);
    check("t5_unit2_one_ack", ack_cnt[2], 1);
    check_queue_empty("t5_no_retry_start");

    // 6: reset mid-run with two units busy
    do_reset();
    exp_start(1, 0, 0); exp_start(2, 1, 1);
    run_start(2);
    while (cyc < t0 + 3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_ack", unit_ack, 0);
    check("t6_start", unit_start, 0);
    check("t6_best_valid", best_valid, 0);
    repeat (8) @(negedge clk);
    check("t6_stale_done_held", unit_done[1:0], 2'b11);
    check("t6_stale_unacked", ack_cnt[0] + ack_cnt[1], 0);
    check_queue_empty("t6_first_run_starts");
    @(negedge clk); #1 models_clear_unit(0);
    plan_inl[0] = 11;
    for (int i = 0; i < 16; i++) attempts[i] = 0;
    exp_start(1, 0, 0);
    run_start(1);
    wait_done(60);
    check("t6_best_inliers", best_inliers, 11);
    check("t6_unit0_ack", ack_cnt[0], 1);
    check("t6_unit1_never_acked", ack_cnt[1], 0);
    check_queue_empty("t6_restart_at_id0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ransac_iteration_scheduler.md
Name: ransac_iteration_scheduler

Overview:
Dispatches RANSAC iterations to a pool of NUM_UNITS plane checking units and collects their plane_checking_unit_status_e results. Retries bus failures and tracks the best inlier count seen. Sits between the top-level control registers and the plane checking unit array. Reports completion or fatal error back to control.

Parameters:
NUM_UNITS, 4, number of plane checking units scheduled (1..16)
ITER_WIDTH, 16, width of iteration count and iteration id
INLIER_WIDTH, 32, width of inlier count per iteration
MAX_RETRIES, 2, bus-error/timeout retries allowed per iteration before fatal

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a run; sampled only in IDLE or DONE
total_iterations  in  ITER_WIDTH  iterations for this run; latched at start
busy  out  1  run in progress (RUN or DRAIN)
done  out  1  run finished; held until next start or reset
fatal_error  out  1  run aborted on retry exhaustion; valid while done=1
unit_start  out  NUM_UNITS  one-cycle start pulse per unit
unit_iter_id  out  NUM_UNITS*ITER_WIDTH  iteration id per unit; stable while that unit is busy
unit_done  in  NUM_UNITS  level, held by unit until acked
unit_status  in  NUM_UNITS*2  plane_checking_unit_status_e per unit; valid with unit_done
unit_inliers  in  NUM_UNITS*INLIER_WIDTH  inlier count; valid with unit_done and SUCCESS
unit_ack  out  NUM_UNITS  one-cycle acknowledge of a unit_done
best_inliers  out  INLIER_WIDTH  largest SUCCESS inlier count this run
best_iter_id  out  ITER_WIDTH  iteration id producing best_inliers
best_valid  out  1  at least one SUCCESS recorded this run
error_count  out  ITER_WIDTH  non-SUCCESS results this run (saturating)

Behaviour:
- Reset: all outputs 0; state IDLE; every unit marked idle; next_iter=0, completed=0, per-unit retry counters 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start at cycle T: latch total_iterations; clear best_*, error_count, fatal_error, counters; done=0. Enter RUN with busy=1 at T+1. If total_iterations=0, go to DONE instead: done=1 at T+1, best_valid=0.
- Start while busy is ignored.
- Dispatch (RUN only), at most one new iteration per cycle:
  - Condition: next_iter<total and some unit is tracked idle.
  - Pulse unit_start of the lowest-index idle unit, drive unit_iter_id=next_iter, mark unit busy, zero its retry counter, increment next_iter.
  - First dispatch occurs in cycle T+1.
- Completion: at most one ack per cycle, to the lowest-index tracked-busy unit with unit_done=1. unit_done from a tracked-idle unit is ignored, never acked.
  - SUCCESS: completed++. If !best_valid or inliers>best_inliers (strict; ties keep earlier), update best_inliers/best_iter_id and set best_valid. Unit becomes idle in the next cycle.
  - DERIVE_PLANE_ERROR: completed++, error_count++. No retry; unit becomes idle.
  - BUS_ERROR or BUS_TIMEOUT: error_count++.
    - Retry counter < MAX_RETRIES: counter++, unit stays busy, unit_start re-pulses on that unit the cycle after ack with the same unit_iter_id.
    - Otherwise: set fatal_error, unit becomes idle, go to DRAIN.
- Re-pulse of a retried unit and a new dispatch to a different unit may occur in the same cycle.
- The acked unit is not eligible for new dispatch in the ack cycle.
- RUN to DONE when completed==total and no unit is tracked busy: done=1, busy=0 the next cycle.
- DRAIN: no dispatches and no retries. Keep acking completions; SUCCESS results still update best_*. When no unit is tracked busy, go to DONE with fatal_error=1.
- error_count saturates at all-ones.
- Reset mid-run: immediate return to reset state; any units still holding unit_done are ignored until dispatched again.
- Arithmetic: counters are ITER_WIDTH unsigned; inlier compare is unsigned.

Test Plan:
1. NUM_UNITS=4, total=6, all SUCCESS with inliers {10,40,25,40,5,30} by id, each unit responds 3 cycles after start.
   - Expect: ids 0..3 to units 0..3 on T+1..T+4, ids 4,5 reissued on freed units.
   - Final: done=1, best_inliers=40, best_iter_id=1, error_count=0.
2. total=0, start.
   - Expect: done=1 at T+1, busy never 1, best_valid=0, no unit_start.
3. Unit 0 returns BUS_TIMEOUT twice then SUCCESS(7) for id 0.
   - Expect: unit_start[0] pulses 3 times, all with id 0; error_count=2; best_inliers=7; fatal_error=0.
4. Unit 1 returns BUS_ERROR 3 times (MAX_RETRIES=2) while unit 0 is busy.
   - Expect: fatal_error=1 and DRAIN after the third ack; no further unit_start; unit 0's SUCCESS(9) is still acked and recorded; done=1 once unit 0 acks.
5. Units 0 and 2 assert unit_done in the same cycle.
   - Expect: unit_ack[0] in cycle N, unit_ack[2] in cycle N+1.
   - DERIVE_PLANE_ERROR on one: error_count++, no retry, iteration counted complete.
6. rst asserted mid-run with 2 units busy.
   - Expect: all outputs 0 next cycle; stale unit_done not acked; a new start begins at id 0.
